uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 44 ++++
 rtl/uart_tx_arbiter_fifo.sv | 54 +++++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, FSM encoding and arbitration helpers for the three-requester
// UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int NREQ     = 3;
    localparam int REQ_PS2  = 0;
    localparam int REQ_UART = 1;
    localparam int REQ_RES  = 2;

    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Round-robin pick: first ready requester found searching from last+1 mod NREQ.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] ready,
                                                input logic [1:0]      last);
        logic [NREQ-1:0] pick;
        logic [1:0]      idx;
        pick = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NREQ);
            if (ready[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// Synchronous character FIFO with fall-through head; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates three character streams onto one UART transmitter, holding the
// grant for a whole LF-terminated message and spacing send pulses.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GUARD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8*NREQ-1:0] req_dat,
    input  logic [NREQ-1:0]   req_wen,
    output logic [NREQ-1:0]   req_full,
    input  logic              tx_ready,
    output logic [7:0]        tx_dat,
    output logic              tx_send,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ovf
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [1:0]      r_last;
    logic [7:0]      r_tx_dat;
    logic            r_tx_send;
    logic [NREQ-1:0] r_ovf;
    logic [GW-1:0]   r_guard_cnt;

    logic [NREQ-1:0] w_full;
    logic [NREQ-1:0] w_empty;
    logic [NREQ-1:0] w_pop;
    logic [NREQ-1:0] w_grant_eff;
    logic [7:0]      w_fifo_dout [NREQ];
    logic [7:0]      w_head;
    logic            w_take;
    logic            w_release;
    logic [GW-1:0]   w_guard_load;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
        char_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (8)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (req_wen[gi]),
            .i_din   (req_dat[8*gi +: 8]),
            .i_pop   (w_pop[gi]),
            .o_dout  (w_fifo_dout[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi])
        );
    end

    // A held grant wins; otherwise the round-robin pick is taken this very cycle.
    assign w_grant_eff  = (r_grant != '0) ? r_grant : rr_pick(~w_empty, r_last);
    assign w_pop        = w_take ? w_grant_eff : '0;
    assign w_guard_load = GW'((GUARD > 0) ? GUARD - 1 : 0);

    always_comb begin
        w_head = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_eff[i]) w_head = w_head | w_fifo_dout[i];
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_eff != '0 && tx_ready) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND:  w_state_nxt = (GUARD == 0) ? ST_WAIT : ST_GUARD;
            ST_GUARD: if (r_guard_cnt == '0) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (tx_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_release   = (r_tx_dat == CHAR_LF) || ((r_grant & w_empty) != '0);
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_last      <= 2'(NREQ - 1);
            r_tx_dat    <= '0;
            r_tx_send   <= 1'b0;
            r_ovf       <= '0;
            r_guard_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_send <= w_take;
            r_ovf     <= r_ovf | (req_wen & w_full & ~w_pop);
            if (w_take) r_tx_dat <= w_head;
            if (r_state == ST_IDLE && r_grant == '0 && w_grant_eff != '0) begin
                r_grant <= w_grant_eff;
                r_last  <= onehot_idx(w_grant_eff);
            end
            if (w_release) r_grant <= '0;
            if (r_state == ST_SEND) begin
                r_guard_cnt <= w_guard_load;
            end else if (r_state == ST_GUARD && r_guard_cnt != '0) begin
                r_guard_cnt <= r_guard_cnt - 1'b1;
            end
        end
    end

    assign req_full = w_full;
    assign tx_dat   = r_tx_dat;
    assign tx_send  = r_tx_send;
    assign grant    = r_grant;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle-accurate vector table for the
// first send, then hand-written sequences for ordering, overflow, reset and rr.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int DEPTH   = 8;
    localparam int GUARD   = 2;
    localparam int SPACING = GUARD + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] req_dat;
    logic [2:0]  req_wen;
    logic [2:0]  req_full;
    logic        tx_ready;
    logic [7:0]  tx_dat;
    logic        tx_send;
    logic [2:0]  grant;
    logic [2:0]  ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] got_dat[$];
    logic [2:0] got_grant[$];
    int         got_cyc[$];
    logic [7:0] exp_dat[$];
    logic [2:0] exp_grant[$];

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] wen;
        logic [23:0] dat;
        logic       ready;
        logic       exp_send;
        logic [7:0] exp_dat;
        logic [2:0] exp_grant;
        logic [2:0] exp_full;
        logic [2:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];

    uart_tx_arbiter #(
        .DEPTH (DEPTH),
        .GUARD (GUARD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_dat  (req_dat),
        .req_wen  (req_wen),
        .req_full (req_full),
        .tx_ready (tx_ready),
        .tx_dat   (tx_dat),
        .tx_send  (tx_send),
        .grant    (grant),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the edge and every send pulse is logged.
    task automatic step();
        @(posedge clk);
        #1;
        if (tx_send === 1'b1) begin
            got_dat.push_back(tx_dat);
            got_grant.push_back(grant);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        got_dat.delete();
        got_grant.delete();
        got_cyc.delete();
        exp_dat.delete();
        exp_grant.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req_wen  = '0;
        req_dat  = '0;
        tx_ready = 1'b1;
        step();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic expect_pulse(input logic [7:0] d, input logic [2:0] g);
        exp_dat.push_back(d);
        exp_grant.push_back(g);
    endtask

    task automatic check_pulses(input string name);
        check({name, ".count"}, got_dat.size(), exp_dat.size());
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            check($sformatf("%s.dat%0d", name, i), got_dat[i], exp_dat[i]);
            check($sformatf("%s.grant%0d", name, i), got_grant[i], exp_grant[i]);
            if (i > 0)
                check($sformatf("%s.gap%0d", name, i), got_cyc[i] - got_cyc[i-1], SPACING);
        end
    endtask

    task automatic add_vec(input string name, input logic r, input logic [2:0] w,
                           input logic [23:0] d, input logic rdy, input logic es,
                           input logic [7:0] ed, input logic [2:0] eg,
                           input logic [2:0] ef, input logic [2:0] eo);
        vec_t v;
        v.name = name; v.rst = r; v.wen = w; v.dat = d; v.ready = rdy;
        v.exp_send = es; v.exp_dat = ed; v.exp_grant = eg; v.exp_full = ef; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req_wen  = '0;
        req_dat  = '0;
        tx_ready = 1'b1;

        // Each row: inputs applied before an edge, outputs expected just after it.
        add_vec("reset",     1, 3'b000, 24'h0,     1, 0, 8'h00, 3'b000, 3'b000, 3'b000);
        add_vec("push_A",    0, 3'b001, 24'h000041, 1, 0, 8'h00, 3'b000, 3'b000, 3'b000);
        add_vec("send_A",    0, 3'b000, 24'h0,     1, 1, 8'h41, 3'b001, 3'b000, 3'b000);
        add_vec("guard1",    0, 3'b000, 24'h0,     1, 0, 8'h41, 3'b001, 3'b000, 3'b000);
        add_vec("guard2",    0, 3'b000, 24'h0,     1, 0, 8'h41, 3'b001, 3'b000, 3'b000);
        add_vec("wait",      0, 3'b000, 24'h0,     1, 0, 8'h41, 3'b001, 3'b000, 3'b000);
        add_vec("release",   0, 3'b000, 24'h0,     1, 0, 8'h41, 3'b000, 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            req_wen  = vecs[i].wen;
            req_dat  = vecs[i].dat;
            tx_ready = vecs[i].ready;
            step();
            check({vecs[i].name, ".tx_send"},  tx_send,  vecs[i].exp_send);
            check({vecs[i].name, ".tx_dat"},   tx_dat,   vecs[i].exp_dat);
            check({vecs[i].name, ".grant"},    grant,    vecs[i].exp_grant);
            check({vecs[i].name, ".req_full"}, req_full, vecs[i].exp_full);
            check({vecs[i].name, ".ovf"},      ovf,      vecs[i].exp_ovf);
        end

        // Two LF-terminated messages queued together must not interleave.
        do_reset();
        req_wen = 3'b110; req_dat = {8'h32, 8'h31, 8'h00}; step();
        req_wen = 3'b110; req_dat = {CHAR_LF, CHAR_LF, 8'h00}; step();
        req_wen = '0; req_dat = '0;
        idle_cycles(30);
        expect_pulse(8'h31, 3'b010);
        expect_pulse(CHAR_LF, 3'b010);
        expect_pulse(8'h32, 3'b100);
        expect_pulse(CHAR_LF, 3'b100);
        check_pulses("msg_order");

        // Nine pushes into a stalled DEPTH-8 FIFO: last one dropped and flagged.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req_wen = 3'b001;
            req_dat = {16'h0000, 8'(8'h50 + i)};
            step();
            if (i == 6) check("ovf.full_at7", req_full, 3'b000);
            if (i == 7) begin
                check("ovf.full_at8", req_full, 3'b001);
                check("ovf.ovf_at8",  ovf,      3'b000);
            end
            if (i == 8) begin
                check("ovf.full_at9", req_full, 3'b001);
                check("ovf.ovf_at9",  ovf,      3'b001);
            end
        end
        req_wen = '0; req_dat = '0;
        check("ovf.no_send_stalled", got_dat.size(), 0);
        tx_ready = 1'b1;
        idle_cycles(8 * SPACING + 10);
        for (int i = 0; i < 8; i++) expect_pulse(8'(8'h50 + i), 3'b001);
        check_pulses("ovf_drain");
        check("ovf.sticky",     ovf,      3'b001);
        check("ovf.full_after", req_full, 3'b000);
        check("ovf.grant_after", grant,   3'b000);

        // Reset during GUARD with three characters still queued.
        do_reset();
        req_wen = 3'b001; req_dat = 24'h000061; step();
        req_wen = 3'b001; req_dat = 24'h000062; step();
        check("rst_mid.send_a", tx_send, 1'b1);
        check("rst_mid.dat_a",  tx_dat,  8'h61);
        req_wen = 3'b001; req_dat = 24'h000063; step();
        req_wen = 3'b001; req_dat = 24'h000064; step();
        check("rst_mid.in_guard_send",  tx_send, 1'b0);
        check("rst_mid.in_guard_grant", grant,   3'b001);
        req_wen = '0; req_dat = '0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid.tx_send",  tx_send,  1'b0);
        check("rst_mid.grant",    grant,    3'b000);
        check("rst_mid.tx_dat",   tx_dat,   8'h00);
        check("rst_mid.req_full", req_full, 3'b000);
        check("rst_mid.ovf",      ovf,      3'b000);
        clear_log();
        idle_cycles(30);
        check("rst_mid.nothing_after", got_dat.size(), 0);

        // Grants released on empty FIFO; round-robin pointer then wraps.
        do_reset();
        req_wen = 3'b101; req_dat = {8'h78, 8'h00, 8'h78}; step();
        req_wen = '0; req_dat = '0;
        idle_cycles(15);
        expect_pulse(8'h78, 3'b001);
        expect_pulse(8'h78, 3'b100);
        check_pulses("rr_empty");
        check("rr_empty.grant_idle", grant, 3'b000);

        clear_log();
        req_wen = 3'b011; req_dat = {8'h00, 8'h71, 8'h70}; step();
        req_wen = '0; req_dat = '0;
        idle_cycles(15);
        expect_pulse(8'h70, 3'b001);
        expect_pulse(8'h71, 3'b010);
        check_pulses("rr_wrap");

        clear_log();
        req_wen = 3'b101; req_dat = {8'h73, 8'h00, 8'h72}; step();
        req_wen = '0; req_dat = '0;
        idle_cycles(15);
        expect_pulse(8'h73, 3'b100);
        expect_pulse(8'h72, 3'b001);
        check_pulses("rr_from2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
